// File: rtl/wb_stage_reg.sv
// MEM->WB pipeline register: latches LANES writeback results per cycle with
// stall hold/bubble handling, flush, rdy freeze, x0/conflict write suppression and a retire counter.
module wb_stage_reg #(
  parameter int LANES   = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int STALL_W = 6,
  parameter int STAGE   = 4,
  parameter int CNT_W   = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic [STALL_W-1:0]        stall,
  input  logic                      flush,
  input  logic [LANES-1:0]          in_valid,
  input  logic [LANES-1:0]          in_wreg,
  input  logic [LANES*ADDR_W-1:0]   in_wd,
  input  logic [LANES*DATA_W-1:0]   in_wdata,
  output logic [LANES-1:0]          wb_valid,
  output logic [LANES-1:0]          wb_wreg,
  output logic [LANES*ADDR_W-1:0]   wb_wd,
  output logic [LANES*DATA_W-1:0]   wb_wdata,
  output logic [CNT_W-1:0]          retire_cnt
);

  logic [LANES-1:0]        valid_reg;
  logic [LANES-1:0]        wreg_reg;
  logic [LANES*ADDR_W-1:0] wd_reg;
  logic [LANES*DATA_W-1:0] wdata_reg;
  logic [CNT_W-1:0]        cnt_reg;

  logic [LANES-1:0]        wreg_next;
  logic [CNT_W-1:0]        retire_inc;
  logic                    hold_dn;
  logic                    stall_unused;

  // The last stage has no downstream neighbour, so it can only ever bubble.
  generate
    if (STAGE + 1 < STALL_W) begin : g_hold_dn
      assign hold_dn = stall[STAGE+1];
    end else begin : g_no_hold_dn
      assign hold_dn = 1'b0;
    end
  endgenerate

  assign stall_unused = ^stall;

  // A lane loses its write if x0 is the target or a later lane writes the same register.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [ADDR_W-1:0] wd_lane;
      logic              shadowed;

      assign wd_lane = in_wd[gi*ADDR_W +: ADDR_W];

      always_comb begin
        shadowed = 1'b0;
        for (int j = gi + 1; j < LANES; j++) begin
          if (in_valid[j] && in_wreg[j] && (in_wd[j*ADDR_W +: ADDR_W] == wd_lane))
            shadowed = 1'b1;
        end
      end

      assign wreg_next[gi] = in_valid[gi] & in_wreg[gi] & (wd_lane != '0) & ~shadowed;
    end
  endgenerate

  always_comb begin
    retire_inc = '0;
    for (int i = 0; i < LANES; i++)
      retire_inc = retire_inc + CNT_W'(valid_reg[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= '0;
      wreg_reg  <= '0;
      wd_reg    <= '0;
      wdata_reg <= '0;
      cnt_reg   <= '0;
    end else if (rdy) begin
      if (flush || (stall[STAGE] && !hold_dn)) begin
        valid_reg <= '0;
        wreg_reg  <= '0;
        wd_reg    <= '0;
        wdata_reg <= '0;
        cnt_reg   <= cnt_reg + retire_inc;
      end else if (!stall[STAGE]) begin
        valid_reg <= in_valid;
        wreg_reg  <= wreg_next;
        wd_reg    <= in_wd;
        wdata_reg <= in_wdata;
        cnt_reg   <= cnt_reg + retire_inc;
      end
      // Held contents are neither replaced nor counted until released.
    end
  end

  assign wb_valid   = valid_reg;
  assign wb_wreg    = wreg_reg;
  assign wb_wd      = wd_reg;
  assign wb_wdata   = wdata_reg;
  assign retire_cnt = cnt_reg;

endmodule

// File: tb/tb_wb_stage_reg.sv
// Scoreboard bench for wb_stage_reg: the driver queues hand-computed expectations,
// a negedge monitor pops and compares them against the registered outputs.
module tb_wb_stage_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [5:0]  stall;
  logic        flush;
  logic [1:0]  in_valid;
  logic [1:0]  in_wreg;
  logic [9:0]  in_wd;
  logic [63:0] in_wdata;

  logic [1:0]  wb_valid;
  logic [1:0]  wb_wreg;
  logic [9:0]  wb_wd;
  logic [63:0] wb_wdata;
  logic [63:0] retire_cnt;

  logic [1:0]  s_valid;
  logic [1:0]  s_wreg;
  logic [9:0]  s_wd;
  logic [63:0] s_wdata;
  logic [3:0]  s_cnt;

  always #5 clk = ~clk;

  wb_stage_reg #(.LANES(2), .DATA_W(32), .ADDR_W(5), .STALL_W(6), .STAGE(3), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wreg(in_wreg), .in_wd(in_wd), .in_wdata(in_wdata),
    .wb_valid(wb_valid), .wb_wreg(wb_wreg), .wb_wd(wb_wd), .wb_wdata(wb_wdata),
    .retire_cnt(retire_cnt)
  );

  // Narrow-counter copy on the same stimulus, used for the wrap check.
  wb_stage_reg #(.LANES(2), .DATA_W(32), .ADDR_W(5), .STALL_W(6), .STAGE(3), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_wreg(in_wreg), .in_wd(in_wd), .in_wdata(in_wdata),
    .wb_valid(s_valid), .wb_wreg(s_wreg), .wb_wd(s_wd), .wb_wdata(s_wdata),
    .retire_cnt(s_cnt)
  );

  typedef struct {
    logic [1:0]  v;
    logic [1:0]  w;
    logic [9:0]  wd;
    logic [63:0] wdata;
    logic [63:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_pass = 0;
  int   n_total = 0;
  int   n_txn = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL txn %0d %s: got 0x%0h expected 0x%0h", n_txn, name, act, req);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      check("wb_valid", 64'(wb_valid), 64'(e.v));
      check("wb_wreg", 64'(wb_wreg), 64'(e.w));
      check("wb_wd", 64'(wb_wd), 64'(e.wd));
      check("wb_wdata", wb_wdata, e.wdata);
      check("retire_cnt", retire_cnt, e.cnt);
      check("retire_cnt_w4", 64'(s_cnt), 64'(e.cnt[3:0]));
      $display("txn %0d: valid=%b wreg=%b wd=0x%0h wdata=0x%0h cnt=%0d cnt4=%0d",
               n_txn, wb_valid, wb_wreg, wb_wd, wb_wdata, retire_cnt, s_cnt);
      n_txn++;
    end
  end

  task automatic step(
    input logic r, input logic y, input logic [5:0] s, input logic f,
    input logic [1:0] iv, input logic [1:0] iw,
    input logic [4:0] a1, input logic [4:0] a0,
    input logic [31:0] d1, input logic [31:0] d0,
    input logic [1:0] ev, input logic [1:0] ew,
    input logic [4:0] ea1, input logic [4:0] ea0,
    input logic [31:0] ed1, input logic [31:0] ed0,
    input logic [63:0] ec
  );
    exp_t x;
    rst = r; rdy = y; stall = s; flush = f;
    in_valid = iv; in_wreg = iw; in_wd = {a1, a0}; in_wdata = {d1, d0};
    @(posedge clk);
    x.v = ev; x.w = ew; x.wd = {ea1, ea0}; x.wdata = {ed1, ed0}; x.cnt = ec;
    q.push_back(x);
    #1;
  endtask

  initial begin
    rst = 1'b0; rdy = 1'b1; stall = '0; flush = 1'b0;
    in_valid = '0; in_wreg = '0; in_wd = '0; in_wdata = '0;
    @(negedge clk);

    // Reset with junk inputs, including rdy low and flush.
    step(0,1,6'h00,0, 2'b11,2'b11, 9,4, 32'hAAAA,32'h5555,  2'b00,2'b00, 0,0, 0,0, 0);
    step(0,0,6'h3F,1, 2'b01,2'b10, 1,2, 32'h1,32'h2,        2'b00,2'b00, 0,0, 0,0, 0);
    // First load; invalid lane1 with same address must not shadow lane0.
    step(1,1,6'h00,0, 2'b01,2'b11, 3,3, 32'h12345678,32'hDEADBEEF,
         2'b01,2'b01, 3,3, 32'h12345678,32'hDEADBEEF, 0);
    // Same-address conflict: higher lane wins.
    step(1,1,6'h00,0, 2'b11,2'b11, 7,7, 32'h22,32'h11,      2'b11,2'b10, 7,7, 32'h22,32'h11, 1);
    // x0 write on lane1 is suppressed but stays valid.
    step(1,1,6'h00,0, 2'b11,2'b11, 0,5, 32'h33,32'h44,      2'b11,2'b01, 0,5, 32'h33,32'h44, 3);
    // Hold for three cycles: contents and counter frozen.
    for (int i = 0; i < 3; i++)
      step(1,1,6'b011111,0, 2'b01,2'b01, 0,9, 32'h0,32'h99, 2'b11,2'b01, 0,5, 32'h33,32'h44, 3);
    // Bubble releases the dual-valid entry.
    step(1,1,6'b001111,0, 2'b11,2'b11, 1,1, 32'h5,32'h6,    2'b00,2'b00, 0,0, 0,0, 5);
    step(1,1,6'h00,0, 2'b10,2'b10, 12,0, 32'hC0FFEE,32'h0,  2'b10,2'b10, 12,0, 32'hC0FFEE,32'h0, 5);
    step(1,1,6'h00,0, 2'b11,2'b11, 2,1, 32'hB,32'hA,        2'b11,2'b11, 2,1, 32'hB,32'hA, 6);
    // Hold, then flush over an all-ones stall: bubble and held entry counted.
    step(1,1,6'h3F,0, 2'b11,2'b11, 8,8, 32'h1,32'h2,        2'b11,2'b11, 2,1, 32'hB,32'hA, 6);
    step(1,1,6'h3F,1, 2'b11,2'b11, 8,8, 32'h1,32'h2,        2'b00,2'b00, 0,0, 0,0, 8);
    step(1,1,6'h00,0, 2'b11,2'b01, 4,6, 32'h44444444,32'h66666666,
         2'b11,2'b01, 4,6, 32'h44444444,32'h66666666, 8);
    // rdy low: nothing moves regardless of stall/flush/inputs.
    step(1,0,6'h00,0, 2'b00,2'b00, 0,0, 0,0,                2'b11,2'b01, 4,6, 32'h44444444,32'h66666666, 8);
    step(1,0,6'h3F,1, 2'b11,2'b11, 1,1, 32'h7,32'h7,        2'b11,2'b01, 4,6, 32'h44444444,32'h66666666, 8);
    step(1,0,6'b001111,0, 2'b10,2'b01, 2,3, 32'h8,32'h9,    2'b11,2'b01, 4,6, 32'h44444444,32'h66666666, 8);
    step(1,0,6'b011111,1, 2'b01,2'b10, 3,2, 32'h9,32'h8,    2'b11,2'b01, 4,6, 32'h44444444,32'h66666666, 8);
    step(1,1,6'h00,0, 2'b01,2'b01, 0,31, 32'h0,32'hFFFFFFFF, 2'b01,2'b01, 0,31, 32'h0,32'hFFFFFFFF, 10);
    // Reset mid-hold discards contents and clears the counter.
    step(1,1,6'b011111,0, 2'b11,2'b11, 5,5, 32'h1,32'h1,    2'b01,2'b01, 0,31, 32'h0,32'hFFFFFFFF, 10);
    step(0,1,6'b011111,0, 2'b11,2'b11, 5,5, 32'h1,32'h1,    2'b00,2'b00, 0,0, 0,0, 0);
    // Wrap: retire 15 then 2 more; the 4-bit counter must read 1.
    step(1,1,6'h00,0, 2'b01,2'b00, 0,0, 32'h0,32'h0,        2'b01,2'b00, 0,0, 0,0, 0);
    for (int i = 0; i < 8; i++)
      step(1,1,6'h00,0, 2'b11,2'b00, 0,0, 32'h0,32'h0,      2'b11,2'b00, 0,0, 0,0, (i == 0) ? 64'd1 : 64'(1 + 2*i));
    step(1,1,6'h00,0, 2'b00,2'b00, 0,0, 32'h0,32'h0,        2'b00,2'b00, 0,0, 0,0, 17);
    step(1,1,6'h00,0, 2'b00,2'b00, 0,0, 32'h0,32'h0,        2'b00,2'b00, 0,0, 0,0, 17);

    repeat (3) @(negedge clk);
    n_total++;
    if (q.size() == 0) n_pass++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
